// File: rtl/uart_bus_arbiter.sv
// Two-way arbiter sharing one UART TX/RX pair between the fetch and memory engines.
// Define UART_ARB_ROUND_ROBIN_EN for round-robin contention; default is fixed memory priority.
module uart_bus_arbiter #(
  parameter logic [15:0] TIMEOUT = 16'd1023
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       f_req,
  input  logic       f_tx_start_n,
  input  logic [7:0] f_tx_data,
  input  logic       m_req,
  input  logic       m_tx_start_n,
  input  logic [7:0] m_tx_data,
  input  logic       uart_tx_done,
  input  logic       uart_rx_do,
  output logic       f_grant,
  output logic       m_grant,
  output logic       f_tx_done,
  output logic       f_rx_do,
  output logic       m_tx_done,
  output logic       m_rx_do,
  output logic       uart_tx_start_n,
  output logic [7:0] uart_tx_data,
  output logic       timeout,
  output logic [1:0] state_dbg
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_GRANT_F = 2'd1;
  localparam logic [1:0] S_GRANT_M = 2'd2;
  localparam logic [1:0] S_GAP     = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [15:0] wd_q, wd_d;
  logic        last_m_q, last_m_d;
  logic        timeout_q, timeout_d;
  logic        arb_f, arb_m;
  logic        holder_req;
  logic        activity;

  always_comb begin
    arb_f = f_req;
    arb_m = m_req;
    if (f_req && m_req) begin
`ifdef UART_ARB_ROUND_ROBIN_EN
      // last_m_q low means fetch won last time, so memory gets this one.
      arb_m = ~last_m_q;
`else
      arb_m = 1'b1;
`endif
      arb_f = ~arb_m;
    end
  end

  always_comb begin
    state_d    = state_q;
    wd_d       = wd_q;
    last_m_d   = last_m_q;
    timeout_d  = 1'b0;
    holder_req = (state_q == S_GRANT_F) ? f_req : m_req;
    activity   = uart_tx_done | uart_rx_do;
    case (state_q)
      S_IDLE, S_GAP: begin
        if (arb_f) begin
          state_d  = S_GRANT_F;
          wd_d     = 16'd0;
          last_m_d = 1'b0;
        end else if (arb_m) begin
          state_d  = S_GRANT_M;
          wd_d     = 16'd0;
          last_m_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GRANT_F, S_GRANT_M: begin
        // A voluntary release takes precedence over the watchdog; activity beats expiry.
        if (!holder_req) begin
          state_d = S_GAP;
        end else if (activity) begin
          wd_d = 16'd0;
        end else if ((TIMEOUT != 16'd0) && (wd_q == TIMEOUT)) begin
          state_d   = S_GAP;
          timeout_d = 1'b1;
        end else begin
          wd_d = wd_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      wd_q      <= 16'd0;
      last_m_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wd_q      <= wd_d;
      last_m_q  <= last_m_d;
      timeout_q <= timeout_d;
    end
  end

  assign f_grant   = (state_q == S_GRANT_F);
  assign m_grant   = (state_q == S_GRANT_M);
  assign timeout   = timeout_q;
  assign state_dbg = state_q;

  assign f_tx_done = uart_tx_done & f_grant;
  assign f_rx_do   = uart_rx_do & f_grant;
  assign m_tx_done = uart_tx_done & m_grant;
  assign m_rx_do   = uart_rx_do & m_grant;

  always_comb begin
    uart_tx_start_n = 1'b1;
    uart_tx_data    = 8'h00;
    if (f_grant) begin
      uart_tx_start_n = f_tx_start_n;
      uart_tx_data    = f_tx_data;
    end else if (m_grant) begin
      uart_tx_start_n = m_tx_start_n;
      uart_tx_data    = m_tx_data;
    end
  end

endmodule

// File: tb/tb_uart_bus_arbiter.sv
// Directed bench for uart_bus_arbiter with a short watchdog (TIMEOUT = 8).
module tb_uart_bus_arbiter;

  localparam logic [15:0] TO = 16'd8;
  localparam logic [15:0] ST_IDLE = 16'd0;
  localparam logic [15:0] ST_GAP  = 16'd3;

  logic       clk = 1'b0;
  logic       reset;
  logic       f_req, f_tx_start_n, m_req, m_tx_start_n;
  logic [7:0] f_tx_data, m_tx_data;
  logic       uart_tx_done, uart_rx_do;
  logic       f_grant, m_grant, f_tx_done, f_rx_do, m_tx_done, m_rx_do;
  logic       uart_tx_start_n, timeout;
  logic [7:0] uart_tx_data;
  logic [1:0] state_dbg;

  int n_cmp  = 0;
  int n_fail = 0;

  uart_bus_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_tx_start_n(f_tx_start_n), .f_tx_data(f_tx_data),
    .m_req(m_req), .m_tx_start_n(m_tx_start_n), .m_tx_data(m_tx_data),
    .uart_tx_done(uart_tx_done), .uart_rx_do(uart_rx_do),
    .f_grant(f_grant), .m_grant(m_grant),
    .f_tx_done(f_tx_done), .f_rx_do(f_rx_do),
    .m_tx_done(m_tx_done), .m_rx_do(m_rx_do),
    .uart_tx_start_n(uart_tx_start_n), .uart_tx_data(uart_tx_data),
    .timeout(timeout), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_grants(input string tag, input logic ef, input logic em, input logic eto);
    check({tag, "_f_grant"}, {15'd0, f_grant}, {15'd0, ef});
    check({tag, "_m_grant"}, {15'd0, m_grant}, {15'd0, em});
    check({tag, "_timeout"}, {15'd0, timeout}, {15'd0, eto});
  endtask

  initial begin
    reset = 1'b0;
    f_req = 1'b0; f_tx_start_n = 1'b1; f_tx_data = 8'h00;
    m_req = 1'b0; m_tx_start_n = 1'b1; m_tx_data = 8'h00;
    uart_tx_done = 1'b0; uart_rx_do = 1'b0;
    repeat (2) tick();
    check_grants("rst", 1'b0, 1'b0, 1'b0);
    check("rst_start_n", {15'd0, uart_tx_start_n}, 16'd1);
    check("rst_data", {8'd0, uart_tx_data}, 16'h0000);
    check("rst_state", {14'd0, state_dbg}, ST_IDLE);
    reset = 1'b1;
    tick();

    // Ungranted starts and pulses are masked / dropped.
    m_tx_start_n = 1'b0; m_tx_data = 8'hAA; uart_tx_done = 1'b1; uart_rx_do = 1'b1;
    #1;
    check("mask_start_n", {15'd0, uart_tx_start_n}, 16'd1);
    check("mask_data", {8'd0, uart_tx_data}, 16'h0000);
    check("drop_f_tx_done", {15'd0, f_tx_done}, 16'd0);
    check("drop_m_tx_done", {15'd0, m_tx_done}, 16'd0);
    check("drop_m_rx_do", {15'd0, m_rx_do}, 16'd0);
    m_tx_start_n = 1'b1; m_tx_data = 8'h00; uart_tx_done = 1'b0; uart_rx_do = 1'b0;

    // Fetch alone: grant one cycle later, its byte on the UART, done routed to fetch only.
    f_req = 1'b1; f_tx_data = 8'h03;
    tick();
    check_grants("f_only", 1'b1, 1'b0, 1'b0);
    f_tx_start_n = 1'b0;
    #1;
    check("f_start_n", {15'd0, uart_tx_start_n}, 16'd0);
    check("f_data", {8'd0, uart_tx_data}, 16'h0003);
    uart_tx_done = 1'b1;
    #1;
    check("f_tx_done", {15'd0, f_tx_done}, 16'd1);
    check("f_m_tx_done", {15'd0, m_tx_done}, 16'd0);
    tick();
    uart_tx_done = 1'b0; f_tx_start_n = 1'b1; uart_rx_do = 1'b1;
    #1;
    check("f_rx_do", {15'd0, f_rx_do}, 16'd1);
    check("f_m_rx_do", {15'd0, m_rx_do}, 16'd0);
    tick();
    uart_rx_do = 1'b0; f_req = 1'b0;
    tick();
    check_grants("f_rel_gap", 1'b0, 1'b0, 1'b0);
    check("f_rel_gap_state", {14'd0, state_dbg}, ST_GAP);
    tick();
    check("f_rel_idle", {14'd0, state_dbg}, ST_IDLE);

    // Two simultaneous contentions with release in between.
    f_req = 1'b1; m_req = 1'b1;
    tick();
    check_grants("cont1", 1'b0, 1'b1, 1'b0);
    f_req = 1'b0; m_req = 1'b0;
    repeat (2) tick();
    f_req = 1'b1; m_req = 1'b1;
    tick();
`ifdef UART_ARB_ROUND_ROBIN_EN
    check_grants("cont2", 1'b1, 1'b0, 1'b0);
`else
    check_grants("cont2", 1'b0, 1'b1, 1'b0);
`endif
    f_req = 1'b0; m_req = 1'b0;
    repeat (2) tick();
    check("cont_idle", {14'd0, state_dbg}, ST_IDLE);

    // Memory holds, fetch waits; release hands over through one GAP cycle.
    m_req = 1'b1;
    tick();
    check_grants("hand_m", 1'b0, 1'b1, 1'b0);
    f_req = 1'b1; m_tx_start_n = 1'b0; m_tx_data = 8'h5C;
    tick();
    check_grants("hand_nopre", 1'b0, 1'b1, 1'b0);
    check("hand_m_start_n", {15'd0, uart_tx_start_n}, 16'd0);
    check("hand_m_data", {8'd0, uart_tx_data}, 16'h005C);
    m_req = 1'b0;
    tick();
    check_grants("hand_gap", 1'b0, 1'b0, 1'b0);
    check("hand_gap_start_n", {15'd0, uart_tx_start_n}, 16'd1);
    tick();
    check_grants("hand_f", 1'b1, 1'b0, 1'b0);
    m_tx_start_n = 1'b1; m_tx_data = 8'h00; f_req = 1'b0;
    repeat (2) tick();

    // Watchdog: grant at cycle g, held through g+8, dropped at g+9 with one timeout pulse.
    f_req = 1'b1;
    tick();
    check_grants("wd_g", 1'b1, 1'b0, 1'b0);
    m_req = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check_grants($sformatf("wd_hold%0d", i), 1'b1, 1'b0, 1'b0);
    end
    tick();
    check_grants("wd_revoke", 1'b0, 1'b0, 1'b1);
    tick();
    check_grants("wd_next_m", 1'b0, 1'b1, 1'b0);
    f_req = 1'b0; m_req = 1'b0;
    repeat (2) tick();

    // Activity in the cycle the counter reaches TIMEOUT wins over the revoke.
    f_req = 1'b1;
    tick();
    repeat (8) tick();
    uart_tx_done = 1'b1;
    tick();
    uart_tx_done = 1'b0;
    check_grants("wd_edge_act", 1'b1, 1'b0, 1'b0);
    repeat (8) tick();
    check_grants("wd_edge_hold", 1'b1, 1'b0, 1'b0);
    tick();
    check_grants("wd_edge_revoke", 1'b0, 1'b0, 1'b1);
    f_req = 1'b0;
    repeat (2) tick();

    // rx_do every 5 cycles keeps the grant alive for 100 cycles.
    f_req = 1'b1;
    tick();
    for (int i = 1; i <= 100; i++) begin
      uart_rx_do = ((i % 5) == 0);
      tick();
      check_grants($sformatf("wd_alive%0d", i), 1'b1, 1'b0, 1'b0);
    end
    uart_rx_do = 1'b0; f_req = 1'b0;
    repeat (2) tick();

    // Asynchronous reset mid-transaction.
    m_req = 1'b1;
    tick();
    check_grants("ar_m", 1'b0, 1'b1, 1'b0);
    m_tx_start_n = 1'b0; m_tx_data = 8'h5A;
    #1;
    check("ar_pre_data", {8'd0, uart_tx_data}, 16'h005A);
    #1;
    reset = 1'b0;
    #1;
    check_grants("ar_async", 1'b0, 1'b0, 1'b0);
    check("ar_start_n", {15'd0, uart_tx_start_n}, 16'd1);
    check("ar_data", {8'd0, uart_tx_data}, 16'h0000);
    m_req = 1'b0; m_tx_start_n = 1'b1; m_tx_data = 8'h00;
    tick();
    reset = 1'b1;
    tick();
    check("ar_idle", {14'd0, state_dbg}, ST_IDLE);
    check_grants("ar_after", 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_bus_arbiter.md
# uart_bus_arbiter

Shares the single UART transmitter/receiver pair between two requesters: the instruction fetch engine and the data memory read/write engine. It grants the UART to one requester at a time and muxes that requester's `tx_start_n`/`tx_data` onto the UART. It routes `tx_done`/`rx_do` back only to the grant holder and revokes a grant that goes silent for too long. It sits between the CPU-side fetch/RW sequencers and the UART TX/RX blocks.

## Interface

- `TIMEOUT`, default 16'd1023: idle cycles allowed while granted before the grant is revoked; 0 disables the watchdog.
- `clk` in 1: system clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `f_req` in 1: fetch requests the UART; held high for the whole transaction.
- `f_tx_start_n` in 1: fetch TX start, active-low.
- `f_tx_data` in 8: fetch TX byte.
- `m_req` in 1: memory R/W requests the UART.
- `m_tx_start_n` in 1: memory TX start, active-low.
- `m_tx_data` in 8: memory TX byte.
- `uart_tx_done` in 1: UART byte transmitted, one-cycle pulse.
- `uart_rx_do` in 1: UART byte received, one-cycle pulse.
- `f_grant` out 1: fetch owns the UART (registered).
- `m_grant` out 1: memory owns the UART (registered).
- `f_tx_done` out 1: equals `uart_tx_done & f_grant`.
- `f_rx_do` out 1: equals `uart_rx_do & f_grant`.
- `m_tx_done` out 1: equals `uart_tx_done & m_grant`.
- `m_rx_do` out 1: equals `uart_rx_do & m_grant`.
- `uart_tx_start_n` out 1: granted requester's `tx_start_n`; 1 when nothing is granted.
- `uart_tx_data` out 8: granted requester's `tx_data`; 8'h00 when nothing is granted.
- `timeout` out 1: one-cycle pulse (registered) when a grant is revoked by the watchdog.

## Operation

- FSM states: IDLE, GRANT_F, GRANT_M, GAP. Reset state is IDLE.
- Reset values: grants 0, `timeout` 0, watchdog counter 0, last-winner register = fetch. With no grant, the muxed outputs are `uart_tx_start_n`=1 and `uart_tx_data`=0.
- IDLE and GAP both arbitrate on the current `f_req`/`m_req`:
  - Only one request: that requester wins.
  - Both request: the priority rule applies (see Configuration).
  - No requests: next state IDLE.
  - A winner moves the FSM to GRANT_F or GRANT_M and updates the last-winner register.
- GRANT_x:
  - Stays while `x_req`=1 and the watchdog has not expired.
  - If `x_req`=0, goes to GAP.
  - No preemption: the other request waits however long the holder keeps the grant.
- GAP: exactly one cycle with both grants 0, so the UART idles and the active-low start line returns high between owners.
- Watchdog, 16-bit counter:
  - Clears on entry to GRANT_x.
  - While granted, clears on any `uart_tx_done` or `uart_rx_do` pulse; otherwise increments.
  - When counter == `TIMEOUT` (and `TIMEOUT` != 0): next state GAP and `timeout` pulses.
  - A requester still holding `req` after a revoke is arbitrated as a fresh request in GAP.
- Routing is combinational from the registered grant.
  - Pulses arriving while nothing is granted are dropped.
  - `rx_data` is not handled here; it is broadcast to both requesters outside this block.
- Reset asserted mid-transaction: everything returns to the reset values asynchronously and any UART byte in flight is abandoned. The owner sees its grant fall.

## Timing

- Request → grant from IDLE: `req` high in cycle n gives grant high in cycle n+1.
- Release → next grant: holder's `req` low in cycle n gives its grant low at n+1 (GAP). The competing grant rises at n+2.
- Watchdog: with no activity, a grant taken at cycle g is dropped at g+`TIMEOUT`+1, with `timeout` high for that single cycle.
- A requester asserts `tx_start_n`=0 only while its grant is high. A start driven without a grant is masked.
- An activity pulse in the same cycle the counter reaches `TIMEOUT` clears the counter; activity wins and there is no revoke.

## Configuration

- `UART_ARB_ROUND_ROBIN_EN` defined: on simultaneous requests, the requester that did not win last time wins. The last-winner register resets to fetch, so the first contention goes to memory.
- Not defined: fixed priority, memory always beats fetch on simultaneous requests. The last-winner register is still maintained but is unused.

## Test plan

- Reset, then `f_req`=1 only → `f_grant`=1 one cycle later. `f_tx_start_n`=0 with `f_tx_data`=8'h03 appears on the UART. `uart_tx_done` pulse appears only on `f_tx_done`.
- `f_req` and `m_req` both rise in the same cycle, twice in a row with release between. Fixed mode → memory both times. Round-robin mode → memory, then fetch.
- Memory granted, `f_req` pending, memory drops `m_req` at cycle n → `m_grant`=0 at n+1 with `uart_tx_start_n`=1, then `f_grant`=1 at n+2.
- `TIMEOUT`=8, fetch granted with no UART pulses → grant drops 9 cycles after grant and `timeout` pulses once. With `m_req` high, memory is granted in the following cycle.
- `TIMEOUT`=8, `uart_rx_do` every 5 cycles while granted → no revoke over 100 cycles.
- `reset` pulled low mid-transaction while memory is granted → `m_grant`=0, `uart_tx_start_n`=1 and `uart_tx_data`=0 immediately. After release, the arbiter is IDLE.
